// File: rtl/seg7_scan.sv
// Purpose : 4-digit common-anode 7-segment scanner fed by a valid/ready value+dp stream.
// Latency : o_dig/o_seg follow the scan index and display register by one clock;
//           an accepted value becomes visible at the next frame boundary.
// Backpressure: one-entry pending buffer; o_ready is low while it holds a value,
//           and it frees up on the cycle after the frame-boundary commit.
// Ports: i_clk/i_rst (sync, active-high), i_valid/o_ready handshake, i_bcd (16b, nibble n = digit n),
//        i_dp (4b), o_seg (active-low {dp,g..a}), o_dig (active-low one-hot), o_frame (boundary pulse).
module seg7_scan #(
  parameter int SCAN_WAIT = 10000,
  parameter int BITS      = 14,
  parameter int BLANK_LZ  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_dig,
  output logic        o_frame
);

  localparam logic [BITS-1:0] LP_TC = BITS'(SCAN_WAIT - 1);

  logic [BITS-1:0] r_pre;
  logic [1:0]      r_idx;
  logic [15:0]     r_disp_bcd;
  logic [3:0]      r_disp_dp;
  logic [15:0]     r_pend_bcd;
  logic [3:0]      r_pend_dp;
  logic            r_pend_full;
  logic [7:0]      r_seg;
  logic [3:0]      r_dig;

  logic            w_tick;
  logic            w_frame;
  logic [3:0]      w_nib;
  logic [3:0]      w_lz;
  logic            w_blank;

  // Active-low glyphs for segments g..a; the dp bit is added separately.
  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0: f_glyph = 7'h40;
      4'h1: f_glyph = 7'h79;
      4'h2: f_glyph = 7'h24;
      4'h3: f_glyph = 7'h30;
      4'h4: f_glyph = 7'h19;
      4'h5: f_glyph = 7'h12;
      4'h6: f_glyph = 7'h02;
      4'h7: f_glyph = 7'h78;
      4'h8: f_glyph = 7'h00;
      4'h9: f_glyph = 7'h10;
      4'hA: f_glyph = 7'h08;
      4'hB: f_glyph = 7'h03;
      4'hC: f_glyph = 7'h46;
      4'hD: f_glyph = 7'h21;
      4'hE: f_glyph = 7'h06;
      default: f_glyph = 7'h0E;
    endcase
  endfunction

  assign w_tick  = (r_pre == LP_TC);
  // Gated with reset so a boundary pulse can never escape while the block is being cleared.
  assign w_frame = w_tick && (r_idx == 2'd3) && !i_rst;

  assign w_nib = r_disp_bcd[{r_idx, 2'b00} +: 4];

  // w_lz[n]: nibble n and every higher nibble are zero; digit 0 is never blanked.
  assign w_lz[3] = (r_disp_bcd[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] && (r_disp_bcd[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] && (r_disp_bcd[7:4]  == 4'h0);
  assign w_lz[0] = 1'b0;
  assign w_blank = (BLANK_LZ != 0) && w_lz[r_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre       <= '0;
      r_idx       <= 2'd0;
      r_disp_bcd  <= 16'h0000;
      r_disp_dp   <= 4'h0;
      r_pend_bcd  <= 16'h0000;
      r_pend_dp   <= 4'h0;
      r_pend_full <= 1'b0;
      r_seg       <= 8'hFF;
      r_dig       <= 4'hF;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end

      // Commit only at the frame boundary so a frame never mixes two values.
      // With pending empty at the boundary, a same-cycle offer fills pending instead.
      if (w_frame && r_pend_full) begin
        r_disp_bcd  <= r_pend_bcd;
        r_disp_dp   <= r_pend_dp;
        r_pend_full <= 1'b0;
      end else if (i_valid && !r_pend_full) begin
        r_pend_bcd  <= i_bcd;
        r_pend_dp   <= i_dp;
        r_pend_full <= 1'b1;
      end

      // Digit select and segments switch on the same edge: no two-digit ghost cycle.
      r_dig <= ~(4'b0001 << r_idx);
      r_seg <= {~r_disp_dp[r_idx], (w_blank ? 7'h7F : f_glyph(w_nib))};
    end
  end

  assign o_ready = !r_pend_full;
  assign o_seg   = r_seg;
  assign o_dig   = r_dig;
  assign o_frame = w_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with SCAN_WAIT=10: a blanking and a non-blanking instance
// share all inputs; per-digit expectations are queued as values are offered and
// popped as each scan frame is observed.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] bcd;
  logic [3:0]  dp;

  logic        rdy,   rdy_nb;
  logic [7:0]  seg,   seg_nb;
  logic [3:0]  dig,   dig_nb;
  logic        frame, frame_nb;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic [7:0] seg_nb;
  } exp_t;

  exp_t sb[$];

  logic [7:0] gly [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_WAIT(10), .BITS(4), .BLANK_LZ(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy),
    .i_bcd(bcd), .i_dp(dp), .o_seg(seg), .o_dig(dig), .o_frame(frame)
  );

  seg7_scan #(.SCAN_WAIT(10), .BITS(4), .BLANK_LZ(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_nb),
    .i_bcd(bcd), .i_dp(dp), .o_seg(seg_nb), .o_dig(dig_nb), .o_frame(frame_nb)
  );

  // Queue the four digits (0..3) one frame of value v/d should display.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    exp_t       t [4];
    logic       lz;
    logic [3:0] nib;
    logic [7:0] g;
    lz = 1'b1;
    for (int n = 3; n >= 0; n--) begin
      nib = v[n*4 +: 4];
      g   = gly[nib];
      lz  = lz && (nib == 4'h0);
      t[n].dig    = ~(4'b0001 << n);
      t[n].seg    = {~d[n], ((lz && n != 0) ? 7'h7F : g[6:0])};
      t[n].seg_nb = {~d[n], g[6:0]};
    end
    for (int n = 0; n < 4; n++) sb.push_back(t[n]);
  endtask

  // Observe one 40-cycle frame starting at the next edge; the boundary pulse
  // is expected on the next-to-last cycle of digit 3.
  task automatic check_scan();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got 0 queued digits, need 1");
        e = '0;
      end else begin
        e = sb.pop_front();
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        total++;
        if (dig !== e.dig || dig_nb !== e.dig) begin
          bad++; $display("FAIL dig d%0d c%0d: got %b/%b need %b", d, c, dig, dig_nb, e.dig);
        end
        total++;
        if (seg !== e.seg) begin
          bad++; $display("FAIL seg d%0d c%0d: got %h need %h", d, c, seg, e.seg);
        end
        total++;
        if (seg_nb !== e.seg_nb) begin
          bad++; $display("FAIL seg_nb d%0d c%0d: got %h need %h", d, c, seg_nb, e.seg_nb);
        end
        total++;
        if (frame !== 1'((d == 3) && (c == 8))) begin
          bad++; $display("FAIL frame d%0d c%0d: got %b need %b", d, c, frame, (d == 3) && (c == 8));
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (seg !== 8'hFF || seg_nb !== 8'hFF) begin
      bad++; $display("FAIL %s seg: got %h/%h need ff", tag, seg, seg_nb);
    end
    total++;
    if (dig !== 4'hF || dig_nb !== 4'hF) begin
      bad++; $display("FAIL %s dig: got %h/%h need f", tag, dig, dig_nb);
    end
    total++;
    if (rdy !== 1'b1 || frame !== 1'b0) begin
      bad++; $display("FAIL %s rdy/frame: got %b/%b need 1/0", tag, rdy, frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; bcd = 16'h0; dp = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    push_frame(16'h0000, 4'h0);
    check_scan();
    push_frame(16'h0000, 4'h0);
    check_scan();
  endtask

  task automatic test_send();
    int n;
    push_frame(16'h0000, 4'h0);
    fork
      begin
        check_scan();
        check_scan();
      end
      begin
        repeat (6) @(negedge clk);
        valid = 1'b1; bcd = 16'h1234; dp = 4'b0100;
        @(negedge clk);
        valid = 1'b0;
        push_frame(16'h1234, 4'b0100);
        total++;
        if (rdy !== 1'b0) begin
          bad++; $display("FAIL send_rdy_drop: got %b need 0", rdy);
        end
        n = 0;
        while (rdy !== 1'b1 && n < 100) begin
          @(negedge clk); n++;
        end
        total++;
        if (n != 33) begin
          bad++; $display("FAIL send_rdy_return: got %0d cycles need 33", n);
        end
      end
    join
    total++;
    if (rdy !== 1'b1) begin
      bad++; $display("FAIL send_rdy_idle: got %b need 1", rdy);
    end
  endtask

  task automatic test_blank();
    push_frame(16'h1234, 4'b0100);
    fork
      begin
        check_scan();
        check_scan();
      end
      begin
        repeat (3) @(negedge clk);
        valid = 1'b1; bcd = 16'h00A5; dp = 4'h0;
        @(negedge clk);
        valid = 1'b0;
        push_frame(16'h00A5, 4'h0);
      end
    join
  endtask

  task automatic test_back_to_back();
    int n;
    push_frame(16'h00A5, 4'h0);
    fork
      begin
        check_scan();
        check_scan();
        check_scan();
      end
      begin
        repeat (4) @(negedge clk);
        valid = 1'b1; bcd = 16'h1111; dp = 4'h0;
        @(negedge clk);
        push_frame(16'h1111, 4'h0);
        total++;
        if (rdy !== 1'b0) begin
          bad++; $display("FAIL b2b_rdy_drop: got %b need 0", rdy);
        end
        bcd = 16'h2222;
        n = 0;
        while (rdy !== 1'b1 && n < 100) begin
          @(negedge clk); n++;
        end
        total++;
        if (n != 35) begin
          bad++; $display("FAIL b2b_wait: got %0d cycles need 35", n);
        end
        @(negedge clk);
        valid = 1'b0;
        push_frame(16'h2222, 4'h0);
        total++;
        if (rdy !== 1'b0) begin
          bad++; $display("FAIL b2b_second_accept: got rdy %b need 0", rdy);
        end
      end
    join
  endtask

  task automatic test_boundary_xfer();
    push_frame(16'h2222, 4'h0);
    push_frame(16'h2222, 4'h0);
    fork
      begin
        check_scan();
        check_scan();
        check_scan();
      end
      begin
        repeat (39) @(negedge clk);
        valid = 1'b1; bcd = 16'h5678; dp = 4'b1000;
        @(negedge clk);
        valid = 1'b0;
        push_frame(16'h5678, 4'b1000);
        total++;
        if (rdy !== 1'b0) begin
          bad++; $display("FAIL boundary_xfer_rdy: got %b need 0", rdy);
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid = 1'b1; bcd = 16'h9999; dp = 4'hF;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (rdy !== 1'b0) begin
      bad++; $display("FAIL rstmid_pending: got rdy %b need 0", rdy);
    end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    @(negedge clk);
    rst = 1'b0;
    push_frame(16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    check_scan();
    check_scan();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send();
    test_blank();
    test_back_to_back();
    test_boundary_xfer();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d entries need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage for the 4-digit counter blocks: accepts a 4-digit BCD/hex value plus decimal points over a valid/ready handshake.
- Multiplexes the value onto a 4-digit common-anode 7-segment display: glyph decode, per-digit scan timing and leading-zero blanking.
- New values are double-buffered and committed only at a scan-frame boundary, so a digit never tears mid-frame.

Parameters:
- SCAN_WAIT, 10000: clocks each digit stays lit; must be >= 2.
- BITS, 14: prescaler width; 2^BITS must be > SCAN_WAIT-1.
- BLANK_LZ, 1: 1 = blank leading zeros on digits 3..1; 0 = show all digits.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream offers i_bcd/i_dp this cycle
- o_ready  out  1  block can accept a new value
- i_bcd  in  16  nibble n = digit n; digit 0 is rightmost
- i_dp  in  4  bit n set = decimal point lit on digit n
- o_seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- o_dig  out  4  active-low one-hot digit select; bit n = digit n
- o_frame  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (i_rst=1 at a clock edge): prescaler=0, digit index=0, display register (value+dp)=0, pending register empty.
- Reset output values: o_seg=8'hFF, o_dig=4'hF, o_frame=0, o_ready=1.
- Reset mid-operation discards the pending value and restarts the scan from digit 0.
- Prescaler:
  - Counts 0..SCAN_WAIT-1, then wraps to 0.
  - The terminal-count cycle is the "tick".
  - On a tick, the index advances 0->1->2->3->0.
- Frame boundary is a tick with index=3. In that cycle:
  - o_frame is 1 (combinational on tick & index==3, so it is 0 during reset).
  - If pending is full, the display register loads it and pending becomes empty.
  - If pending is empty, the display register is held.
- Handshake:
  - A transfer occurs when i_valid & o_ready at a clock edge; the value loads pending and pending becomes full.
  - o_ready = !pending_full (registered state).
  - While pending is full, i_valid is ignored and the value is held until the next boundary.
- Simultaneous transfer and boundary:
  - Pending empty: the transfer fills pending; the display register is unchanged (commit happens at the next boundary).
  - Pending full: no transfer is possible, since o_ready=0.
- After a commit, o_ready returns to 1 on the following cycle.
- Outputs are registered. o_dig/o_seg reflect the index and display register with 1-cycle latency:
  - First edge after reset release: o_dig=4'b1110, o_seg=glyph(display[3:0]).
  - Digit n is lit for exactly SCAN_WAIT cycles.
- Glyphs (active-low, dp off), nibble 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Decimal point: o_seg[7] = ~dp[n], applied after the glyph, including on blanked digits.
- Blanking (BLANK_LZ=1):
  - Digit n (n=3..1) is blanked when its nibble and all higher nibbles are 0.
  - A blanked digit has o_seg[6:0]=7'h7F and o_dig is still driven.
  - Digit 0 is never blanked.
- Only one o_dig bit is low at any time after reset; there is no ghosting cycle with two digits selected.

Test Plan:
- Use SCAN_WAIT=10, BITS=4 for all scenarios.
- Reset, no input:
  - o_seg=FF, o_dig=F during reset.
  - After release: o_dig=1110 with o_seg=C0 for 10 cycles.
  - Digits 1-3 blanked (o_seg=FF).
  - o_frame pulses every 40 cycles.
- Send i_bcd=16'h1234, i_dp=4'b0100 mid-frame:
  - o_ready drops the next cycle.
  - Display is unchanged until o_frame.
  - Then digit0=99, digit1=B0, digit2=24 (A4 with dp), digit3=F9.
  - o_ready returns to 1.
- Send 16'h00A5 with BLANK_LZ=1:
  - digit0=92, digit1=88, digits 2-3 blanked (FF).
  - With BLANK_LZ=0, digits 2-3 show C0.
- Back-to-back offers 16'h1111 then 16'h2222, i_valid held high:
  - Only 1111 is accepted before the boundary.
  - 2222 is accepted the cycle after the commit and shown one frame later.
- Transfer on the boundary-tick cycle: the value is not shown that frame and appears at the following boundary.
- Assert i_rst mid-scan with pending full:
  - Outputs return to FF/F and o_ready=1.
  - Display shows 0 on digit 0 after release; the pending value is lost.
